hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

Hazard detection and operand-forwarding controller for the 5-stage pipeline. It keeps a shadow of the destination register and control flags for the instructions in EX, MEM and WB. From that shadow it produces registered 2-bit select codes for the two 32-bit 4:1 operand-forwarding multiplexers at the ALU inputs. It also raises a combinational load-use stall and squashes the ID instruction on a taken branch.

## Interface
Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_W  ID source register A.
- id_rt  in  REG_W  ID source register B.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_dest  in  REG_W  destination register (already resolved rd/rt/31).
- id_regwrite  in  1  instruction writes the register file.
- id_memread  in  1  instruction is a load.
- flush  in  1  branch/jump taken; squash the ID instruction this cycle.
- stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX (combinational).
- fwd_a_sel  out  2  select code for the ALU operand A mux in EX.
- fwd_b_sel  out  2  select code for the ALU operand B mux in EX.
- stall_cnt  out  CNT_W  load-use stall cycles since reset, saturating.

## Operation
- Select encoding, identical for both muxes:
  - 00 = register-file value latched in ID/EX.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB ALU result.
  - 11 = MEM/WB load data.
- Shadow stages EX, MEM and WB each hold {v, dest, regwrite, memread}. Every cycle: WB <= MEM, MEM <= EX.
- EX loads from ID when id_valid & ~stall & ~flush; otherwise EX loads a bubble (v=0).
- A stage "writes r" when v & regwrite & dest==r & r!=0. Register 0 is never forwarded and never stalls.
- Load-use stall: stall = id_valid & ~flush & EX.memread & EX writes r, for r = id_rs (id_use_rs) or r = id_rt (id_use_rt).
- Forward select, computed for each operand at the edge on which ID advances into EX. Sources are checked in priority order, youngest first:
  - EX writes the operand and is not a load -> 01.
  - else MEM writes the operand: not a load -> 10; load -> 11.
  - else -> 00.
- The EX-load case cannot occur here, because stall blocks it.
- When EX receives a bubble, both selects load 00.
- A register written by WB in the same cycle it is read in ID is not forwarded. The register file is write-through.
- flush beats stall: with both active, stall=0, EX receives a bubble and stall_cnt does not increment.
- stall_cnt increments on each clock edge where stall=1 and holds at all-ones.

## Timing
- Reset (rst_n low, asynchronous): all shadow v=0, fwd_a_sel=fwd_b_sel=00, stall_cnt=0. stall is therefore 0 immediately.
- fwd_*_sel are registered. They change only on clock edges and are valid for the whole cycle the instruction occupies EX, aligned with the ID/EX pipeline register.
- stall is combinational from the ID inputs and EX shadow, with zero latency. It lasts exactly 1 cycle per load-use hazard, because the load then moves to MEM.
- After a stall cycle the held ID instruction enters EX with select 11 for the dependent operand.
- Deassertion of rst_n mid-operation: pipeline resumes empty. The first ID instruction after reset gets 00 selects.

## Test plan
- Back-to-back ALU dependency: `add r3` then `sub` reading r3 as rs -> sub in EX with fwd_a_sel=01, fwd_b_sel=00, stall never 1.
- Distance-2 dependency plus priority: `add r3`, `or r3`, `and` reading r3 as rt -> and gets fwd_b_sel=01 (youngest wins). With `nop` in place of `or` -> 10.
- Load-use: `lw r5`, then `add` reading r5 as rs -> stall=1 for exactly 1 cycle, EX bubble with selects 00, then add in EX with fwd_a_sel=11, stall_cnt=1.
- Register 0: `lw r0` then `add` reading r0 -> stall=0, selects 00.
- Flush during stall: load-use hazard with flush=1 in the same cycle -> stall=0, EX bubble, stall_cnt unchanged.
- Async reset mid-stream: pull rst_n low between edges during a stall -> stall, selects and stall_cnt go to 0 immediately. The next instruction after release gets 00 selects.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - load-use hazard detection and ALU operand forwarding control
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   id_*               instruction currently in ID (sources, destination, control flags)
//   flush              taken branch/jump: squash the ID instruction this cycle
//   stall              combinational load-use stall (freeze PC and IF/ID, bubble ID/EX)
//   fwd_a_sel/b_sel    registered 4:1 mux selects for ALU operands in EX
//                      00 reg file, 01 EX/MEM ALU, 10 MEM/WB ALU, 11 MEM/WB load data
//   stall_cnt          saturating count of load-use stall cycles since reset
module hazard_fwd_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    // Shadow of the instructions in EX and MEM. The WB slot needs no shadow:
    // the register file is write-through, so a WB write is already visible
    // to the ID read and is never a forwarding source.
    logic             ex_v, ex_rw, ex_mr;
    logic [REG_W-1:0] ex_dest;
    logic             mem_v, mem_rw, mem_mr;
    logic [REG_W-1:0] mem_dest;

    logic ex_wr_rs, ex_wr_rt, mem_wr_rs, mem_wr_rt;
    logic advance;
    logic [1:0] fwd_a_next, fwd_b_next;

    // Register 0 is hard-wired, so it is never a hazard or a forwarding source.
    assign ex_wr_rs  = ex_v  & ex_rw  & (ex_dest  == id_rs) & (id_rs != '0);
    assign ex_wr_rt  = ex_v  & ex_rw  & (ex_dest  == id_rt) & (id_rt != '0);
    assign mem_wr_rs = mem_v & mem_rw & (mem_dest == id_rs) & (id_rs != '0);
    assign mem_wr_rt = mem_v & mem_rw & (mem_dest == id_rt) & (id_rt != '0);

    // flush wins over stall: the squashed instruction cannot create a hazard.
    assign stall = id_valid & ~flush & ex_mr &
                   ((id_use_rs & ex_wr_rs) | (id_use_rt & ex_wr_rt));

    assign advance = id_valid & ~stall & ~flush;

    // Youngest producer wins. An EX load never reaches here as a source
    // because it forces a stall, so the EX case only covers ALU results.
    // A MEM producer selects its load data (11) or its ALU result (10).
    always_comb begin
        fwd_a_next = 2'b00;
        fwd_b_next = 2'b00;
        if (id_use_rs) begin
            if (ex_wr_rs && !ex_mr)  fwd_a_next = 2'b01;
            else if (mem_wr_rs)      fwd_a_next = {1'b1, mem_mr};
        end
        if (id_use_rt) begin
            if (ex_wr_rt && !ex_mr)  fwd_b_next = 2'b01;
            else if (mem_wr_rt)      fwd_b_next = {1'b1, mem_mr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v      <= 1'b0;
            ex_rw     <= 1'b0;
            ex_mr     <= 1'b0;
            ex_dest   <= '0;
            mem_v     <= 1'b0;
            mem_rw    <= 1'b0;
            mem_mr    <= 1'b0;
            mem_dest  <= '0;
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
            stall_cnt <= '0;
        end else begin
            mem_v    <= ex_v;
            mem_rw   <= ex_rw;
            mem_mr   <= ex_mr;
            mem_dest <= ex_dest;
            if (advance) begin
                ex_v      <= 1'b1;
                ex_rw     <= id_regwrite;
                ex_mr     <= id_memread;
                ex_dest   <= id_dest;
                fwd_a_sel <= fwd_a_next;
                fwd_b_sel <= fwd_b_next;
            end else begin
                // Bubble: clearing the flags as well keeps a stale load flag
                // from ever qualifying a hazard.
                ex_v      <= 1'b0;
                ex_rw     <= 1'b0;
                ex_mr     <= 1'b0;
                ex_dest   <= '0;
                fwd_a_sel <= 2'b00;
                fwd_b_sel <= 2'b00;
            end
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - directed self-checking bench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 2;   // small counter so saturation is reachable

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [REG_W-1:0] id_rs, id_rt, id_dest;
    logic             id_use_rs, id_use_rt, id_regwrite, id_memread, flush;
    logic             stall;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;

    int n_asrt = 0;
    int n_fail = 0;

    hazard_fwd_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_dest     (id_dest),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .stall       (stall),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction in ID: valid, rs, rt, use_rs, use_rt, dest, regwrite, memread, flush
    task automatic issue(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                         input int dest, input logic rw, input logic mr, input logic fl);
        id_valid    = v;
        id_rs       = REG_W'(rs);
        id_rt       = REG_W'(rt);
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_dest     = REG_W'(dest);
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
        #1;
    endtask

    task automatic idle();
        issue(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        // Reset state
        chk("rst_stall", stall, 0);
        chk("rst_a", fwd_a_sel, 0);
        chk("rst_b", fwd_b_sel, 0);
        chk("rst_cnt", stall_cnt, 0);
        tick();
        rst_n = 1'b1;

        // Back-to-back ALU dependency: add r3 ; sub r6 = r3 - r4
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
        chk("b2b_add_stall", stall, 0);
        tick();
        issue(1, 3, 4, 1, 1, 6, 1, 0, 0);
        chk("b2b_sub_stall", stall, 0);
        tick();
        chk("b2b_a", fwd_a_sel, 2'b01);
        chk("b2b_b", fwd_b_sel, 2'b00);
        idle(); tick(); tick();

        // Distance 2 with a younger writer: add r3 ; or r3 ; and rt=r3
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
        issue(1, 5, 3, 1, 1, 7, 1, 0, 0);
        chk("prio_stall", stall, 0);
        tick();
        chk("prio_a", fwd_a_sel, 2'b00);
        chk("prio_b", fwd_b_sel, 2'b01);
        idle(); tick(); tick();

        // Distance 2 with nop between: add r3 ; nop ; and rt=r3
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
        idle(); tick();
        chk("nop_bubble_b", fwd_b_sel, 2'b00);
        issue(1, 5, 3, 1, 1, 7, 1, 0, 0); tick();
        chk("dist2_a", fwd_a_sel, 2'b00);
        chk("dist2_b", fwd_b_sel, 2'b10);
        idle(); tick(); tick();

        // Load-use on rs: lw r5 ; add r8 = r5 + r6
        issue(1, 1, 0, 1, 0, 5, 1, 1, 0); tick();
        issue(1, 5, 6, 1, 1, 8, 1, 0, 0);
        chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble_a", fwd_a_sel, 2'b00);
        chk("lu_bubble_b", fwd_b_sel, 2'b00);
        chk("lu_cnt", stall_cnt, 1);
        chk("lu_stall_once", stall, 0);
        tick();
        chk("lu_a", fwd_a_sel, 2'b11);
        chk("lu_b", fwd_b_sel, 2'b00);
        chk("lu_cnt_hold", stall_cnt, 1);
        idle(); tick(); tick();

        // Register 0: lw r0 ; add reading r0
        issue(1, 1, 0, 1, 0, 0, 1, 1, 0); tick();
        issue(1, 0, 0, 1, 1, 9, 1, 0, 0);
        chk("r0_stall", stall, 0);
        tick();
        chk("r0_a", fwd_a_sel, 2'b00);
        chk("r0_b", fwd_b_sel, 2'b00);
        idle(); tick(); tick();

        // Flush during load-use hazard
        issue(1, 1, 0, 1, 0, 5, 1, 1, 0); tick();
        issue(1, 5, 6, 1, 1, 8, 1, 0, 1);
        chk("fl_stall", stall, 0);
        tick();
        chk("fl_bubble_a", fwd_a_sel, 2'b00);
        chk("fl_cnt", stall_cnt, 1);
        idle(); tick(); tick();

        // Load-use on rt: lw r9 ; sub rt=r9
        issue(1, 1, 0, 1, 0, 9, 1, 1, 0); tick();
        issue(1, 4, 9, 1, 1, 10, 1, 0, 0);
        chk("lurt_stall", stall, 1);
        tick(); tick();
        chk("lurt_a", fwd_a_sel, 2'b00);
        chk("lurt_b", fwd_b_sel, 2'b11);
        chk("lurt_cnt", stall_cnt, 2);
        idle(); tick(); tick();

        // Two more load-use stalls drive the 2-bit counter to 3 and hold it
        issue(1, 1, 0, 1, 0, 5, 1, 1, 0); tick();
        issue(1, 5, 6, 1, 1, 8, 1, 0, 0); tick(); tick();
        chk("sat_cnt3", stall_cnt, 3);
        idle(); tick();
        issue(1, 1, 0, 1, 0, 5, 1, 1, 0); tick();
        issue(1, 5, 6, 1, 1, 8, 1, 0, 0);
        chk("sat_stall", stall, 1);
        tick(); tick();
        chk("sat_hold", stall_cnt, 3);
        idle(); tick(); tick();

        // Async reset in the middle of a stall: add r3 ; lw r5 (rs=r3) ; add rs=r5
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
        issue(1, 3, 0, 1, 0, 5, 1, 1, 0); tick();
        chk("ar_lw_a", fwd_a_sel, 2'b01);
        issue(1, 5, 3, 1, 1, 8, 1, 0, 0);
        chk("ar_stall_pre", stall, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_stall", stall, 0);
        chk("ar_a", fwd_a_sel, 2'b00);
        chk("ar_cnt", stall_cnt, 0);
        #2 rst_n = 1'b1;
        issue(1, 5, 3, 1, 1, 8, 1, 0, 0);
        chk("ar_post_stall", stall, 0);
        tick();
        chk("ar_post_a", fwd_a_sel, 2'b00);
        chk("ar_post_b", fwd_b_sel, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
